exec_datapath: RTL

- Execution datapath driven by the multicycle control FSM; it is the consumer of that FSM's control word and the producer of its status flags.
- Holds PC, A/B operand registers and the ALUOut register, and contains the source muxes and the ALU.
- Computes the next PC from the selected source and drives the registered status flags (overflow, negativo, zero, igual, maior_que, menor_que) back to the FSM.

---
 rtl/exec_datapath.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/exec_datapath.sv
`default_nettype none
// ============================================================================
// Module   : exec_datapath
// Purpose  : Multicycle execution datapath. Holds the PC, the A/B operand
//            registers and the ALUOut register. Contains the ALU source muxes
//            and the ALU. Registers the status flags that the control FSM
//            samples in the state after an ALU state.
// Ports    : clock, reset          - clock, asynchronous active-high reset
//            alu_src_a/b, alu_op   - ALU operand selects and operation
//            pc_source, pc_write,
//            pc_write_cond,
//            branch_ne             - next-PC select and load controls
//            ab_load               - capture rs_data/rt_data into A/B
//            rs_data, rt_data,
//            imm, jump_target,
//            mdr_data              - datapath inputs
//            pc, alu_result,
//            alu_out               - program counter, ALU result (comb/reg)
//            overflow .. menor_que - registered status flags
// Revision : 1.0 - initial release
// ============================================================================
module exec_datapath #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       alu_src_a,
  input  logic [2:0]       alu_src_b,
  input  logic [2:0]       alu_op,
  input  logic [2:0]       pc_source,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             branch_ne,
  input  logic             ab_load,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm,
  input  logic [25:0]      jump_target,
  input  logic [WIDTH-1:0] mdr_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_out,
  output logic             overflow,
  output logic             negativo,
  output logic             zero,
  output logic             igual,
  output logic             maior_que,
  output logic             menor_que
);

  localparam int               MSB    = WIDTH - 1;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_FOUR = WIDTH'(4);

  // Registers
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             overflow_q, overflow_d;
  logic             negativo_q, negativo_d;
  logic             zero_q, zero_d;
  logic             igual_q, igual_d;
  logic             maior_que_q, maior_que_d;
  logic             menor_que_q, menor_que_d;

  // Immediate extensions and jump target, adapted to the datapath width
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] jump_pc;
  logic [27:0]      jump_field;

  assign jump_field = {jump_target, 2'b00};

  generate
    if (WIDTH >= 16) begin : g_imm_wide
      assign imm_sext = {{(WIDTH-16){imm[15]}}, imm};
      assign imm_zext = {{(WIDTH-16){1'b0}}, imm};
    end else begin : g_imm_narrow
      assign imm_sext = imm[WIDTH-1:0];
      assign imm_zext = imm[WIDTH-1:0];
    end
  endgenerate

  generate
    if (WIDTH > 28) begin : g_jump_wide
      // Upper PC bits select the region, the jump field supplies the rest
      assign jump_pc = {pc_q[WIDTH-1:28], jump_field};
    end else begin : g_jump_narrow
      assign jump_pc = jump_field[WIDTH-1:0];
    end
  endgenerate

  // Source muxes
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  always_comb begin
    src_a = '0;
    case (alu_src_a)
      2'd0:    src_a = pc_q;
      2'd1:    src_a = a_q;
      2'd2:    src_a = mdr_data;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (alu_src_b)
      3'd0:    src_b = b_q;
      3'd1:    src_b = C_FOUR;
      3'd2:    src_b = imm_sext;
      3'd3:    src_b = imm_sext << 2;
      3'd4:    src_b = imm_zext;
      default: src_b = '0;
    endcase
  end

  // ALU
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'd0: alu_res = src_a;
      3'd1: begin
        alu_res = src_a + src_b;
        // Same-sign operands producing a different-sign sum
        alu_ovf = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      3'd2, 3'd7: begin
        alu_res = src_a - src_b;
        // Opposite-sign operands with the result sign flipped from A
        alu_ovf = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      3'd3: alu_res = src_a & src_b;
      3'd4: alu_res = src_a ^ src_b;
      3'd5: alu_res = ~src_a;
      3'd6: begin
        alu_res = src_a + C_ONE;
        alu_ovf = ~src_a[MSB] & alu_res[MSB];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_result = alu_res;

  // Branch decision uses the A/B registers directly, not the ALU path
  logic a_eq_b;
  logic taken;

  assign a_eq_b = (a_q == b_q);
  assign taken  = pc_write_cond & (branch_ne ? ~a_eq_b : a_eq_b);

  // Next-state logic
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    pc_d        = pc_q;
    alu_out_d   = alu_res;
    overflow_d  = alu_ovf;
    negativo_d  = alu_res[MSB];
    zero_d      = (alu_res == '0);
    igual_d     = (src_a == src_b);
    maior_que_d = ($signed(src_a) > $signed(src_b));
    menor_que_d = ($signed(src_a) < $signed(src_b));

    if (ab_load) begin
      a_d = rs_data;
      b_d = rt_data;
    end

    // Compare-only operation leaves ALUOut untouched
    if (alu_op == 3'd7) begin
      alu_out_d = alu_out_q;
    end

    if (pc_write | taken) begin
      case (pc_source)
        3'd0:    pc_d = alu_res;
        3'd1:    pc_d = alu_out_q;
        3'd2:    pc_d = jump_pc;
        3'd3:    pc_d = mdr_data;
        3'd4:    pc_d = EXC_VECTOR;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      overflow_q  <= 1'b0;
      negativo_q  <= 1'b0;
      zero_q      <= 1'b0;
      igual_q     <= 1'b0;
      maior_que_q <= 1'b0;
      menor_que_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      overflow_q  <= overflow_d;
      negativo_q  <= negativo_d;
      zero_q      <= zero_d;
      igual_q     <= igual_d;
      maior_que_q <= maior_que_d;
      menor_que_q <= menor_que_d;
    end
  end

  assign pc        = pc_q;
  assign alu_out   = alu_out_q;
  assign overflow  = overflow_q;
  assign negativo  = negativo_q;
  assign zero      = zero_q;
  assign igual     = igual_q;
  assign maior_que = maior_que_q;
  assign menor_que = menor_que_q;

endmodule
`default_nettype wire
